regfile_port_ctrl: RTL and testbench

Port controller that sits directly upstream of the register-file array built from `sram_1x1` bit cells. It accepts one write and one dual-address read request per cycle. It turns them into registered one-hot write/read select lines and write data for the cell array, captures the array's two read buses, and returns registered read data with a valid strobe. After every reset it runs a zero-initialisation sweep, because the bit cells have no reset. It also forwards same-cycle write data to colliding reads.

---
 rtl/regfile_port_ctrl_if.sv | 35 +++
 rtl/regfile_port_ctrl.sv | 109 ++++++++++
 tb/tb_regfile_port_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_port_ctrl_if.sv
// Request/response and cell-array bus for the register-file port controller.
// The controller takes the slave side; the requester plus bit-cell array take the master side.
interface regfile_port_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  localparam int NREG = 2 ** AW;

  logic            ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rd_req;
  logic [AW-1:0]   rd_addr1;
  logic [AW-1:0]   rd_addr2;
  logic            rd_valid;
  logic [DW-1:0]   rd_data1;
  logic [DW-1:0]   rd_data2;
  logic [DW-1:0]   cell_wd;
  logic [NREG-1:0] cell_ws;
  logic [NREG-1:0] cell_rs1;
  logic [NREG-1:0] cell_rs2;
  logic [DW-1:0]   cell_rd1;
  logic [DW-1:0]   cell_rd2;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr1, rd_addr2, cell_rd1, cell_rd2,
    output ready, rd_valid, rd_data1, rd_data2, cell_wd, cell_ws, cell_rs1, cell_rs2
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr1, rd_addr2, cell_rd1, cell_rd2,
    input  ready, rd_valid, rd_data1, rd_data2, cell_wd, cell_ws, cell_rs1, cell_rs2
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Port controller for a reset-less bit-cell register file: zero-init sweep after reset,
// one registered issue stage driving one-hot selects, registered read return with forwarding.
module regfile_port_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_port_ctrl_if.slave bus
);
  localparam int NREG = 2 ** AW;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_k, w_k_nxt;
  logic [NREG-1:0] r_cell_ws_p1, w_cell_ws_nxt;
  logic [NREG-1:0] r_cell_rs1_p1, w_cell_rs1_nxt;
  logic [NREG-1:0] r_cell_rs2_p1, w_cell_rs2_nxt;
  logic [DW-1:0]   r_cell_wd_p1, w_cell_wd_nxt;
  logic            r_rd_vld_p1, w_rd_vld_nxt;
  logic            r_rd_vld_p2;
  logic [DW-1:0]   r_rd_data1_p2, r_rd_data2_p2;
  logic            w_fwd1, w_fwd2;

  // Register 0 is hard-wired to zero, so address 0 never selects a row.
  function automatic logic [NREG-1:0] onehot_nz(input logic [AW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    if (idx != '0) v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_cell_ws_nxt  = '0;
    w_cell_rs1_nxt = '0;
    w_cell_rs2_nxt = '0;
    w_cell_wd_nxt  = '0;
    w_rd_vld_nxt   = 1'b0;
    case (r_state)
      ST_INIT: begin
        // Leave INIT only once the last row's clearing write has been presented.
        if (r_cell_ws_p1[NREG-1]) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cell_ws_nxt = onehot_nz(r_k);
          if (r_k != AW'(NREG - 1)) w_k_nxt = r_k + AW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.wr_en) begin
          w_cell_ws_nxt = onehot_nz(bus.wr_addr);
          w_cell_wd_nxt = bus.wr_data;
        end
        if (bus.rd_req) begin
          w_cell_rs1_nxt = onehot_nz(bus.rd_addr1);
          w_cell_rs2_nxt = onehot_nz(bus.rd_addr2);
          w_rd_vld_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // A same-stage write to the row being read has not reached the cell yet.
  assign w_fwd1 = |(r_cell_ws_p1 & r_cell_rs1_p1);
  assign w_fwd2 = |(r_cell_ws_p1 & r_cell_rs2_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_k           <= AW'(1);
      r_cell_ws_p1  <= '0;
      r_cell_rs1_p1 <= '0;
      r_cell_rs2_p1 <= '0;
      r_cell_wd_p1  <= '0;
      r_rd_vld_p1   <= 1'b0;
      r_rd_vld_p2   <= 1'b0;
      r_rd_data1_p2 <= '0;
      r_rd_data2_p2 <= '0;
    end else begin
      // Issue stage S1
      r_state       <= w_state_nxt;
      r_k           <= w_k_nxt;
      r_cell_ws_p1  <= w_cell_ws_nxt;
      r_cell_rs1_p1 <= w_cell_rs1_nxt;
      r_cell_rs2_p1 <= w_cell_rs2_nxt;
      r_cell_wd_p1  <= w_cell_wd_nxt;
      r_rd_vld_p1   <= w_rd_vld_nxt;
      // Read return stage
      r_rd_vld_p2   <= r_rd_vld_p1;
      if (r_rd_vld_p1) begin
        r_rd_data1_p2 <= w_fwd1 ? r_cell_wd_p1 : bus.cell_rd1;
        r_rd_data2_p2 <= w_fwd2 ? r_cell_wd_p1 : bus.cell_rd2;
      end
    end
  end

  assign bus.ready    = (r_state == ST_IDLE);
  assign bus.cell_ws  = r_cell_ws_p1;
  assign bus.cell_rs1 = r_cell_rs1_p1;
  assign bus.cell_rs2 = r_cell_rs2_p1;
  assign bus.cell_wd  = r_cell_wd_p1;
  assign bus.rd_valid = r_rd_vld_p2;
  assign bus.rd_data1 = r_rd_data1_p2;
  assign bus.rd_data2 = r_rd_data2_p2;
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: bit-cell array model, register-level reference model
// compared every cycle, and directed vectors with literal expectations.
module tb_regfile_port_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREG = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  regfile_port_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  regfile_port_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bit-cell array: no reset, powers up holding garbage.
  logic [DW-1:0] mem [NREG] = '{default: 8'hEE};

  always @(posedge clk) begin
    for (int r = 0; r < NREG; r++)
      if (bus.cell_ws[r]) mem[r] <= bus.cell_wd;
  end

  always_comb begin
    bus.cell_rd1 = '0;
    bus.cell_rd2 = '0;
    for (int r = 0; r < NREG; r++) begin
      if (bus.cell_rs1[r]) bus.cell_rd1 = bus.cell_rd1 | mem[r];
      if (bus.cell_rs2[r]) bus.cell_rd2 = bus.cell_rd2 | mem[r];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents as seen by requests, updated at acceptance.
  logic [DW-1:0]   ref_reg [NREG] = '{default: '0};
  int              m_cyc = 0;
  logic            m_ready = 1'b0;
  logic [NREG-1:0] m_ws = '0, m_rs1 = '0, m_rs2 = '0;
  logic [DW-1:0]   m_wd = '0;
  logic            s1_rd = 1'b0;
  logic [DW-1:0]   s1_d1 = '0, s1_d2 = '0;
  logic            m_valid = 1'b0;
  logic [DW-1:0]   m_d1 = '0, m_d2 = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) ref_reg[r] = '0;
      m_cyc = 0; m_ready = 1'b0;
      m_ws = '0; m_rs1 = '0; m_rs2 = '0; m_wd = '0;
      s1_rd = 1'b0; m_valid = 1'b0; m_d1 = '0; m_d2 = '0;
    end else begin
      m_valid = s1_rd;
      if (s1_rd) begin m_d1 = s1_d1; m_d2 = s1_d2; end
      m_ws = '0; m_rs1 = '0; m_rs2 = '0; m_wd = '0; s1_rd = 1'b0;
      if (m_ready) begin
        if (bus.wr_en) begin
          m_wd = bus.wr_data;
          if (bus.wr_addr != 0) begin
            m_ws = NREG'(1) << bus.wr_addr;
            ref_reg[bus.wr_addr] = bus.wr_data;
          end
        end
        if (bus.rd_req) begin
          s1_rd = 1'b1;
          m_rs1 = (bus.rd_addr1 != 0) ? NREG'(1) << bus.rd_addr1 : '0;
          m_rs2 = (bus.rd_addr2 != 0) ? NREG'(1) << bus.rd_addr2 : '0;
          s1_d1 = (bus.rd_addr1 != 0) ? ref_reg[bus.rd_addr1] : '0;
          s1_d2 = (bus.rd_addr2 != 0) ? ref_reg[bus.rd_addr2] : '0;
        end
      end
      if (m_cyc < 1000) m_cyc++;
      // Sweep row n is presented after the n-th edge out of reset; requests open after the last.
      if (m_cyc < NREG) m_ws = NREG'(1) << m_cyc;
      m_ready = (m_cyc >= NREG);
    end
  end

  initial forever begin
    @(negedge clk);
    check("ready",    bus.ready,    m_ready);
    check("cell_ws",  bus.cell_ws,  m_ws);
    check("cell_rs1", bus.cell_rs1, m_rs1);
    check("cell_rs2", bus.cell_rs2, m_rs2);
    check("cell_wd",  bus.cell_wd,  m_wd);
    check("rd_valid", bus.rd_valid, m_valid);
    check("rd_data1", bus.rd_data1, m_d1);
    check("rd_data2", bus.rd_data2, m_d2);
  end

  task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rd, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.wr_en = wr; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_req = rd; bus.rd_addr1 = a1; bus.rd_addr2 = a2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ready && n < 20) begin @(negedge clk); n++; end
    check("ready_timeout", bus.ready, 1'b1);
  endtask

  initial begin
    logic [NREG-1:0] exp_ws;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    check("rst_ready", bus.ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_cell_ws", bus.cell_ws, 0);
    #2 rst_n = 1'b1;
    // Requests during INIT must be ignored.
    drive(1, 4, 8'h77, 1, 4, 4);
    exp_ws = 8'h02;
    for (int i = 0; i < NREG - 1; i++) begin
      @(negedge clk);
      check("init_ready", bus.ready, 0);
      check("init_ws", bus.cell_ws, exp_ws);
      check("init_wd", bus.cell_wd, 0);
      exp_ws = exp_ws << 1;
    end
    @(negedge clk);
    check("ready_up", bus.ready, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("init_req_dropped", bus.cell_ws, 0);

    // Cleared registers read zero
    drive(0, 0, 0, 1, 3, 5);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    check("rs1_r3", bus.cell_rs1, 8'h08);
    check("rs2_r5", bus.cell_rs2, 8'h20);
    @(negedge clk);
    check("clr_valid", bus.rd_valid, 1);
    check("clr_d1", bus.rd_data1, 8'h00);
    check("clr_d2", bus.rd_data2, 8'h00);
    @(negedge clk);
    check("clr_single_valid", bus.rd_valid, 0);
    drive(0, 0, 0, 1, 4, 4);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r4_ignored_in_init", bus.rd_data1, 8'h00);

    // Write then read same register
    drive(1, 3, 8'hA5, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    check("wr_ws_r3", bus.cell_ws, 8'h08);
    check("wr_wd", bus.cell_wd, 8'hA5);
    @(negedge clk);
    check("wr_ws_clear", bus.cell_ws, 8'h00);
    drive(0, 0, 0, 1, 3, 3);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r3_valid", bus.rd_valid, 1);
    check("r3_d1", bus.rd_data1, 8'hA5);
    check("r3_d2", bus.rd_data2, 8'hA5);

    // Same-cycle forwarding on port 1 only
    drive(1, 2, 8'h11, 0, 0, 0);
    @(negedge clk);
    drive(1, 6, 8'h3C, 1, 6, 2);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("fwd_d1", bus.rd_data1, 8'h3C);
    check("fwd_d2", bus.rd_data2, 8'h11);

    // Register 0
    drive(1, 0, 8'hFF, 0, 0, 0);
    @(negedge clk);
    check("r0_ws", bus.cell_ws, 8'h00);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    check("r0_rs1", bus.cell_rs1, 8'h00);
    check("r0_rs2", bus.cell_rs2, 8'h00);
    @(negedge clk);
    check("r0_valid", bus.rd_valid, 1);
    check("r0_d1", bus.rd_data1, 8'h00);
    check("r0_d2", bus.rd_data2, 8'h00);

    // Streaming writes then back-to-back reads
    for (int i = 1; i < NREG; i++) begin
      drive(1, AW'(i), DW'(i * 16), 0, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 1, 1, 7);
    @(negedge clk);
    drive(0, 0, 0, 1, 2, 6);
    @(negedge clk);
    check("st0_valid", bus.rd_valid, 1);
    check("st0_d1", bus.rd_data1, 8'h10);
    check("st0_d2", bus.rd_data2, 8'h70);
    drive(0, 0, 0, 1, 3, 5);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    check("st1_valid", bus.rd_valid, 1);
    check("st1_d1", bus.rd_data1, 8'h20);
    check("st1_d2", bus.rd_data2, 8'h60);
    @(negedge clk);
    check("st2_valid", bus.rd_valid, 1);
    check("st2_d1", bus.rd_data1, 8'h30);
    check("st2_d2", bus.rd_data2, 8'h50);
    @(negedge clk);
    check("st_end_valid", bus.rd_valid, 0);
    check("st_hold_d1", bus.rd_data1, 8'h30);

    // Reset while a read and a write are in S1
    drive(1, 5, 8'h99, 1, 3, 3);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    check("pre_rst_rs1", bus.cell_rs1, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.ready, 0);
    check("mid_rst_ws", bus.cell_ws, 0);
    check("mid_rst_rs1", bus.cell_rs1, 0);
    check("mid_rst_d1", bus.rd_data1, 0);
    @(negedge clk);
    check("mid_rst_valid", bus.rd_valid, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("resweep_ws", bus.cell_ws, 8'h02);
    wait_ready();
    drive(0, 0, 0, 1, 3, 5);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_valid", bus.rd_valid, 1);
    check("post_rst_r3", bus.rd_data1, 8'h00);
    check("post_rst_r5", bus.rd_data2, 8'h00);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
